// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared definitions for the SPI slave front end.
// Contents: FSM state encoding, command codes, counter width helper.
package spi_slave_pkg;

    // Gray ordered: IDLE -> RX -> WAIT_TX -> TX -> DONE
    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        RX      = 3'b001,
        WAIT_TX = 3'b011,
        TX      = 3'b010,
        DONE    = 3'b110
    } state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Bits needed to hold the values 0 .. n-1.
    function automatic int clog2(input int n);
        int w;
        int v;
        w = 0;
        v = n - 1;
        while (v > 0) begin
            w++;
            v = v >> 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: up counter with synchronous clear and terminal compare.
// Ports: clk, rst (async high), clear, enable, term (terminal value), tc.
module spi_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] term,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/spi_slave_v2.sv
// spi_slave_v2: SPI slave that receives a command frame on MOSI and
// returns RAM read data on MISO after a bounded tx_valid wait.
// Ports: clk, rst (async high), SS_n, MOSI -> MISO; tx_data/tx_valid in;
//        rx_data/rx_valid (frame strobe), err (strobe), busy out.
module spi_slave_v2 #(
    parameter int DATA_SIZE  = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int TX_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    input  logic [DATA_SIZE-1:0] tx_data,
    input  logic                 tx_valid,
    output logic [DATA_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    output logic                 err,
    output logic                 busy
);

    import spi_slave_pkg::*;

    localparam int FRAME_W = DATA_SIZE + 2;
    localparam int CNT_MAX = (FRAME_W > TX_TIMEOUT) ? FRAME_W : TX_TIMEOUT;
    localparam int CNT_W   = (clog2(CNT_MAX) < 1) ? 1 : clog2(CNT_MAX);

    state_t               state;
    state_t               state_n;
    logic [FRAME_W-1:0]   rx_sh;
    logic [FRAME_W-1:0]   frame_n;
    logic [1:0]           frame_cmd;
    logic [DATA_SIZE-1:0] tx_sh;
    logic                 rd_addr_done;

    logic                 cnt_clr;
    logic                 cnt_en;
    logic [CNT_W-1:0]     cnt_term;
    logic                 cnt_tc;

    logic                 rx_done;
    logic                 rd_err;
    logic                 to_err;
    logic                 tx_start;
    logic                 tx_step;
    logic                 tx_end;

    function automatic logic first_bit(input logic [DATA_SIZE-1:0] v);
        return MSB_FIRST ? v[DATA_SIZE-1] : v[0];
    endfunction

    function automatic logic [DATA_SIZE-1:0] advance(
        input logic [DATA_SIZE-1:0] v
    );
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    // Frame as it stands once the bit on MOSI is taken this edge.
    assign frame_n   = MSB_FIRST ? {rx_sh[FRAME_W-2:0], MOSI}
                                 : {MOSI, rx_sh[FRAME_W-1:1]};
    assign frame_cmd = frame_n[FRAME_W-1:FRAME_W-2];
    assign busy      = (state != IDLE);

    // One counter serves RX bits, WAIT_TX timeout and TX bits.
    spi_bit_counter #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .term   (cnt_term),
        .tc     (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        cnt_term = '0;
        rx_done  = 1'b0;
        rd_err   = 1'b0;
        to_err   = 1'b0;
        tx_start = 1'b0;
        tx_step  = 1'b0;
        tx_end   = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!SS_n) begin
                    state_n = RX;
                end
            end
            RX: begin
                cnt_term = CNT_W'(FRAME_W - 1);
                if (SS_n) begin
                    state_n = IDLE;
                    cnt_clr = 1'b1;
                end else if (cnt_tc) begin
                    rx_done = 1'b1;
                    cnt_clr = 1'b1;
                    unique case (frame_cmd)
                        CMD_RD_DATA: begin
                            if (rd_addr_done) begin
                                state_n = WAIT_TX;
                            end else begin
                                rd_err  = 1'b1;
                                state_n = DONE;
                            end
                        end
                        CMD_RD_ADDR, CMD_WR_ADDR, CMD_WR_DATA: begin
                            state_n = DONE;
                        end
                    endcase
                end else begin
                    cnt_en = 1'b1;
                end
            end
            WAIT_TX: begin
                cnt_term = CNT_W'(TX_TIMEOUT - 1);
                if (SS_n) begin
                    state_n = IDLE;
                    cnt_clr = 1'b1;
                end else if (tx_valid) begin
                    // Data arriving on the last wait cycle still wins.
                    tx_start = 1'b1;
                    cnt_clr  = 1'b1;
                    state_n  = TX;
                end else if (cnt_tc) begin
                    to_err  = 1'b1;
                    cnt_clr = 1'b1;
                    state_n = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            TX: begin
                cnt_term = CNT_W'(DATA_SIZE - 1);
                if (SS_n) begin
                    state_n = IDLE;
                    cnt_clr = 1'b1;
                end else if (cnt_tc) begin
                    tx_end  = 1'b1;
                    cnt_clr = 1'b1;
                    state_n = DONE;
                end else begin
                    tx_step = 1'b1;
                    cnt_en  = 1'b1;
                end
            end
            DONE: begin
                cnt_clr = 1'b1;
                if (SS_n) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sh        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            err          <= 1'b0;
            rd_addr_done <= 1'b0;
            tx_sh        <= '0;
            MISO         <= 1'b0;
        end else begin
            rx_valid <= rx_done;
            err      <= rd_err | to_err;
            if (state == RX && !SS_n) begin
                rx_sh <= frame_n;
            end
            if (rx_done) begin
                rx_data <= frame_n;
            end
            if (rx_done && frame_cmd == CMD_RD_ADDR) begin
                rd_addr_done <= 1'b1;
            end else if (tx_end) begin
                rd_addr_done <= 1'b0;
            end
            // MISO idles low outside an active transmit, including aborts.
            if (tx_start) begin
                tx_sh <= advance(tx_data);
                MISO  <= first_bit(tx_data);
            end else if (tx_step) begin
                tx_sh <= advance(tx_sh);
                MISO  <= first_bit(tx_sh);
            end else begin
                MISO <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_v2.sv
// tb_spi_slave_v2: randomized bench for spi_slave_v2 with a frame-level model.
// Two instances: 8-bit MSB-first (timeout 16) and 16-bit LSB-first (timeout 5).
`timescale 1ns/1ps
module tb_spi_slave_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ss_n;
    logic [1:0]  mosi;
    logic [1:0]  txv;
    logic [7:0]  txd0;
    logic [15:0] txd1;
    logic        miso0, rxv0, er0, busy0;
    logic        miso1, rxv1, er1, busy1;
    logic [9:0]  rxd0;
    logic [17:0] rxd1;

    always #5 clk = ~clk;

    spi_slave_v2 u0 (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (ss_n[0]),
        .MOSI     (mosi[0]),
        .MISO     (miso0),
        .tx_data  (txd0),
        .tx_valid (txv[0]),
        .rx_data  (rxd0),
        .rx_valid (rxv0),
        .err      (er0),
        .busy     (busy0)
    );

    spi_slave_v2 #(
        .DATA_SIZE  (16),
        .MSB_FIRST  (1'b0),
        .TX_TIMEOUT (5)
    ) u1 (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (ss_n[1]),
        .MOSI     (mosi[1]),
        .MISO     (miso1),
        .tx_data  (txd1),
        .tx_valid (txv[1]),
        .rx_data  (rxd1),
        .rx_valid (rxv1),
        .err      (er1),
        .busy     (busy1)
    );

    int          n_chk;
    int          n_pass;
    bit          rd_done [2];
    logic [17:0] last_rx [2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int ds(input int d);
        return (d != 0) ? 16 : 8;
    endfunction

    function automatic int tmo(input int d);
        return (d != 0) ? 5 : 16;
    endfunction

    function automatic bit msb(input int d);
        return (d == 0);
    endfunction

    function automatic logic [15:0] dmask(input int d);
        return (d != 0) ? 16'hFFFF : 16'h00FF;
    endfunction

    // {MISO, rx_valid, err, busy}
    function automatic logic [3:0] obs(input int d);
        return (d != 0) ? {miso1, rxv1, er1, busy1}
                        : {miso0, rxv0, er0, busy0};
    endfunction

    function automatic logic [17:0] rxd(input int d);
        return (d != 0) ? rxd1 : {8'h00, rxd0};
    endfunction

    task automatic set_txd(input int d, input logic [15:0] v);
        if (d != 0) txd1 = v;
        else        txd0 = v[7:0];
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_obs", 32'(obs(d)), 32'h0);
            check("rst_rxd", 32'(rxd(d)), 32'h0);
            rd_done[d] = 1'b0;
            last_rx[d] = '0;
        end
        ss_n = 2'b11;
        txv  = 2'b00;
        mosi = 2'b00;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic done_phase(input int d);
        int         n;
        logic [3:0] acc;
        n   = $urandom_range(0, 2);
        acc = 4'b0001;
        for (int i = 0; i < n; i++) begin
            mosi[d] = 1'($urandom);
            txv[d]  = 1'($urandom);
            cyc();
            acc |= obs(d);
        end
        if (n > 0) check("done_hold", 32'(acc), 32'h1);
        ss_n[d] = 1'b1;
        txv[d]  = 1'b0;
        cyc();
        check("idle", 32'(obs(d)), 32'h0);
    endtask

    // ab_rx: bit index whose edge sees SS_n high (-1 none).
    // txw: WAIT_TX cycle with tx_valid (>= timeout: never).
    // ab_tx: TX bits shown before SS_n abort; 100+j: async reset instead.
    task automatic frame(input int d, input logic [1:0] cmd,
                         input logic [15:0] pay, input int ab_rx,
                         input int txw, input int ab_tx,
                         input logic [15:0] tv);
        int          fw;
        int          pos;
        logic [17:0] f;
        logic [15:0] t;
        logic [15:0] word;
        logic [15:0] mask;
        logic [3:0]  acc;
        logic [3:0]  o;
        bit          exp_err;
        bit          wait_tx;
        bit          got_tx;
        fw = ds(d) + 2;
        f  = (18'(cmd) << ds(d)) | 18'(pay & dmask(d));
        t  = tv & dmask(d);
        ss_n[d] = 1'b0;
        mosi[d] = 1'($urandom);
        cyc();
        check("busy_rx", 32'(obs(d) & 4'b0111), 32'h1);
        acc = 4'b0001;
        for (int i = 0; i < fw; i++) begin
            mosi[d] = msb(d) ? f[fw-1-i] : f[i];
            txv[d]  = 1'($urandom);
            set_txd(d, 16'($urandom));
            if (i == ab_rx) ss_n[d] = 1'b1;
            cyc();
            if (i == ab_rx) begin
                txv[d] = 1'b0;
                check("rx_quiet", 32'(acc), 32'h1);
                check("abort_rx", 32'(obs(d)), 32'h0);
                check("abort_rxd", 32'(rxd(d)), 32'(last_rx[d]));
                return;
            end
            if (i < fw - 1) acc |= obs(d);
        end
        check("rx_quiet", 32'(acc), 32'h1);
        exp_err = (cmd == 2'b11) && !rd_done[d];
        wait_tx = (cmd == 2'b11) && rd_done[d];
        check("rx_valid", 32'(obs(d) & 4'b1100), 32'h4);
        check("rx_data", 32'(rxd(d)), 32'(f));
        check("rd_err", 32'(obs(d) & 4'b0010), exp_err ? 32'h2 : 32'h0);
        last_rx[d] = f;
        if (cmd == 2'b10) rd_done[d] = 1'b1;
        txv[d] = 1'b0;
        if (!wait_tx) begin
            done_phase(d);
            return;
        end
        got_tx = 1'b0;
        acc    = 4'b0001;
        for (int w = 0; w < tmo(d); w++) begin
            txv[d] = (w == txw);
            set_txd(d, (w == txw) ? t : 16'($urandom));
            cyc();
            txv[d] = 1'b0;
            if (w == txw) begin
                got_tx = 1'b1;
                break;
            end
            if (w == tmo(d) - 1) break;
            acc |= obs(d);
        end
        check("wait_quiet", 32'(acc), 32'h1);
        if (!got_tx) begin
            check("timeout", 32'(obs(d)), 32'h3);
            done_phase(d);
            return;
        end
        word = '0;
        mask = '0;
        acc  = 4'b0001;
        for (int j = 0; j < ds(d); j++) begin
            o = obs(d);
            acc |= (o & 4'b0111);
            pos = msb(d) ? ds(d) - 1 - j : j;
            word[pos] = o[3];
            mask[pos] = 1'b1;
            if (j == ab_tx) begin
                ss_n[d] = 1'b1;
                txv[d]  = 1'b0;
                cyc();
                check("tx_part", 32'(word), 32'(t & mask));
                check("abort_tx", 32'(obs(d)), 32'h0);
                return;
            end
            if (j == ab_tx - 100) begin
                check("tx_part", 32'(word), 32'(t & mask));
                do_reset();
                return;
            end
            txv[d]  = 1'($urandom);
            mosi[d] = 1'($urandom);
            cyc();
        end
        txv[d] = 1'b0;
        check("tx_quiet", 32'(acc), 32'h1);
        check("tx_word", 32'(word), 32'(t));
        check("tx_tail", 32'(obs(d)), 32'h1);
        rd_done[d] = 1'b0;
        done_phase(d);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d;
        int          ab_rx;
        int          ab_tx;
        logic [1:0]  cmd;
        n_chk  = 0;
        n_pass = 0;
        for (int i = 0; i < 2; i++) begin
            rd_done[i] = 1'b0;
            last_rx[i] = '0;
        end
        rst  = 1'b1;
        ss_n = 2'b11;
        mosi = 2'b00;
        txv  = 2'b00;
        txd0 = '0;
        txd1 = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_obs", 32'(obs(i)), 32'h0);
            check("reset_rxd", 32'(rxd(i)), 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        frame(0, 2'b00, 16'h00A5, -1, 0, -1, 16'h0);
        frame(0, 2'b11, 16'h0000, -1, 0, -1, 16'h0);
        frame(0, 2'b10, 16'h0003, -1, 0, -1, 16'h0);
        frame(0, 2'b11, 16'h005A, -1, 2, -1, 16'h00C3);
        frame(0, 2'b10, 16'h0011, -1, 0, -1, 16'h0);
        frame(0, 2'b10, 16'h0012, -1, 0, -1, 16'h0);
        frame(0, 2'b11, 16'h0022, -1, 99, -1, 16'h0);
        frame(0, 2'b11, 16'h0033, -1, 15, -1, 16'h0081);
        frame(0, 2'b01, 16'h00FF, 6, 0, -1, 16'h0);
        frame(0, 2'b01, 16'h0055, 9, 0, -1, 16'h0);
        frame(1, 2'b10, 16'h4321, -1, 0, -1, 16'h0);
        frame(1, 2'b11, 16'h1234, -1, 1, 105, 16'hBEEF);
        frame(1, 2'b11, 16'h0000, -1, 0, -1, 16'h0);

        for (int n = 0; n < 80; n++) begin
            d     = int'($urandom_range(0, 1));
            cmd   = 2'($urandom);
            ab_rx = -1;
            ab_tx = -1;
            if ($urandom_range(0, 7) == 0)
                ab_rx = int'($urandom_range(0, ds(d) + 1));
            if ($urandom_range(0, 5) == 0)
                ab_tx = int'($urandom_range(0, ds(d) - 2));
            else if ($urandom_range(0, 11) == 0)
                ab_tx = 100 + int'($urandom_range(0, ds(d) - 2));
            frame(d, cmd, 16'($urandom), ab_rx,
                  int'($urandom_range(0, tmo(d) + 1)), ab_tx,
                  16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
